// File: rtl/neo_pattern_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | neo_pattern_sequencer_if : strand-controller bus for the chaser    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface neo_pattern_sequencer_if;
    logic       enable_i;
    logic [7:0] red_level_i;
    logic [7:0] green_level_i;
    logic [7:0] blue_level_i;
    logic       ready_to_load_i;
    logic       ready_to_send_i;
    logic       load_color_o;
    logic [1:0] color_index_o;
    logic [2:0] pixel_index_o;
    logic [7:0] color_level_o;
    logic       send_it_o;
    logic       busy_o;
    logic       frame_done_o;
    logic [2:0] position_o;

    modport master (
        input  enable_i, red_level_i, green_level_i, blue_level_i,
        input  ready_to_load_i, ready_to_send_i,
        output load_color_o, color_index_o, pixel_index_o, color_level_o,
        output send_it_o, busy_o, frame_done_o, position_o
    );

    modport slave (
        output enable_i, red_level_i, green_level_i, blue_level_i,
        output ready_to_load_i, ready_to_send_i,
        input  load_color_o, color_index_o, pixel_index_o, color_level_o,
        input  send_it_o, busy_o, frame_done_o, position_o
    );
endinterface
`default_nettype wire

// File: rtl/neo_pattern_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | neo_pattern_sequencer : single-pixel chaser driving a LED strand   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module neo_pattern_sequencer #(
    parameter int NUM_PIXELS  = 5,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    neo_pattern_sequencer_if.master        bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [2:0]  LAST_PIX  = 3'(NUM_PIXELS - 1);
    localparam logic [15:0] LAST_HOLD = 16'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  pos_q, pos_d;
    logic [2:0]  pix_q, pix_d;
    logic [1:0]  col_q, col_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  red_q, red_d;
    logic [7:0]  grn_q, grn_d;
    logic [7:0]  blu_q, blu_d;
    logic [7:0]  sel_level;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pos_q   <= 3'd0;
            pix_q   <= 3'd0;
            col_q   <= 2'd0;
            hold_q  <= 16'd0;
            red_q   <= 8'd0;
            grn_q   <= 8'd0;
            blu_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            pix_q   <= pix_d;
            col_q   <= col_d;
            hold_q  <= hold_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
        end
    end

    // Colour code order 00 red, 01 blue, 10 green is also the load order.
    always_comb begin
        case (col_q)
            2'd0:    sel_level = red_q;
            2'd1:    sel_level = blu_q;
            default: sel_level = grn_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        pix_d   = pix_q;
        col_d   = col_q;
        hold_d  = hold_q;
        red_d   = red_q;
        grn_d   = grn_q;
        blu_d   = blu_q;
        bus.load_color_o  = 1'b0;
        bus.color_index_o = 2'd0;
        bus.pixel_index_o = 3'd0;
        bus.color_level_o = 8'd0;
        bus.send_it_o     = 1'b0;
        bus.frame_done_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable_i) begin
                    red_d   = bus.red_level_i;
                    grn_d   = bus.green_level_i;
                    blu_d   = bus.blue_level_i;
                    pix_d   = 3'd0;
                    col_d   = 2'd0;
                    hold_d  = 16'd0;
                    pos_d   = 3'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus.color_index_o = col_q;
                bus.pixel_index_o = pix_q;
                bus.color_level_o = (pix_q == pos_q) ? sel_level : 8'd0;
                if (bus.ready_to_load_i) begin
                    bus.load_color_o = 1'b1;
                    if (col_q == 2'd2) begin
                        col_d = 2'd0;
                        if (pix_q == LAST_PIX) begin
                            state_d = ST_SEND;
                        end else begin
                            pix_d = pix_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            ST_SEND: begin
                if (bus.ready_to_send_i) begin
                    bus.send_it_o    = 1'b1;
                    bus.frame_done_o = 1'b1;
                    hold_d           = 16'd0;
                    state_d          = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == LAST_HOLD) begin
                    hold_d = 16'd0;
                    pix_d  = 3'd0;
                    col_d  = 2'd0;
                    if (bus.enable_i) begin
                        pos_d   = (pos_q == LAST_PIX) ? 3'd0 : pos_q + 3'd1;
                        red_d   = bus.red_level_i;
                        grn_d   = bus.green_level_i;
                        blu_d   = bus.blue_level_i;
                        state_d = ST_LOAD;
                    end else begin
                        pos_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy_o     = (state_q != ST_IDLE);
    assign bus.position_o = pos_q;
endmodule
`default_nettype wire
